// File: rtl/cp0_unit.sv
// Coprocessor-0 subset: Count/Compare timer, Status, Cause, EPC and PRId, plus
// same-cycle exception detection with EPC capture and ERET return.
module cp0_unit #(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0800,
   parameter logic [31:0] PRID_VALUE = 32'h0001_0001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        IsCOP0,
   input  logic        IsEret,
   input  logic        IsMtc0,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] wdata,
   input  logic        syscall,
   input  logic        ri,
   input  logic        ov,
   input  logic [5:0]  ext_int,
   output logic        HasExp,
   output logic [31:0] epc,
   output logic [31:0] exc_vector,
   output logic [31:0] rdata,
   output logic        eret_taken
);

   localparam logic [4:0] ADDR_COUNT   = 5'd9;
   localparam logic [4:0] ADDR_COMPARE = 5'd11;
   localparam logic [4:0] ADDR_STATUS  = 5'd12;
   localparam logic [4:0] ADDR_CAUSE   = 5'd13;
   localparam logic [4:0] ADDR_EPC     = 5'd14;
   localparam logic [4:0] ADDR_PRID    = 5'd15;

   localparam logic [4:0] EXC_INT = 5'd0;
   localparam logic [4:0] EXC_SYS = 5'd8;
   localparam logic [4:0] EXC_RI  = 5'd10;
   localparam logic [4:0] EXC_OV  = 5'd12;

   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic [31:0] epc_q, epc_d;
   logic [5:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   logic [5:0]  ip_q, ip_d;
   logic [4:0]  exc_code_q, exc_code_d;
   logic        timer_pending_q, timer_pending_d;

   logic [5:0]  ip_masked;
   logic        int_req;
   logic        mtc0_en;
   logic [4:0]  exc_code_sel;

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_ip_mask
         assign ip_masked[gi] = ip_q[gi] & im_q[gi];
      end
   endgenerate

   assign int_req    = ie_q & ~exl_q & (|ip_masked);
   // Fault inputs are meaningless while reset is held, so they cannot raise an exception.
   assign HasExp     = ~rst & (int_req | syscall | ri | ov);
   assign eret_taken = IsEret & IsCOP0 & ~HasExp;
   assign mtc0_en    = IsCOP0 & IsMtc0 & ~HasExp;

   always_comb begin
      exc_code_sel = EXC_OV;
      if (int_req) begin
         exc_code_sel = EXC_INT;
      end else if (ri) begin
         exc_code_sel = EXC_RI;
      end else if (syscall) begin
         exc_code_sel = EXC_SYS;
      end
   end

   always_comb begin
      count_d         = count_q + 32'd1;
      compare_d       = compare_q;
      epc_d           = epc_q;
      im_d            = im_q;
      exl_d           = exl_q;
      ie_d            = ie_q;
      exc_code_d      = exc_code_q;
      // IP[15] follows the registered timer flag, so it trails the match by two edges.
      ip_d            = {ext_int[5] | timer_pending_q, ext_int[4:0]};
      timer_pending_d = timer_pending_q | (count_q == compare_q);

      if (HasExp) begin
         epc_d      = pc;
         exl_d      = 1'b1;
         exc_code_d = exc_code_sel;
      end else begin
         if (eret_taken) begin
            exl_d = 1'b0;
         end
         if (mtc0_en) begin
            case (cp0_addr)
               ADDR_COUNT: begin
                  count_d = wdata;
               end
               ADDR_COMPARE: begin
                  compare_d       = wdata;
                  timer_pending_d = 1'b0;
               end
               ADDR_STATUS: begin
                  im_d  = wdata[15:10];
                  exl_d = wdata[1];
                  ie_d  = wdata[0];
               end
               ADDR_EPC: begin
                  epc_d = wdata;
               end
               default: begin
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q         <= 32'h0;
         compare_q       <= 32'hFFFF_FFFF;
         epc_q           <= 32'h0;
         im_q            <= 6'h0;
         exl_q           <= 1'b0;
         ie_q            <= 1'b0;
         ip_q            <= 6'h0;
         exc_code_q      <= 5'h0;
         timer_pending_q <= 1'b0;
      end else begin
         count_q         <= count_d;
         compare_q       <= compare_d;
         epc_q           <= epc_d;
         im_q            <= im_d;
         exl_q           <= exl_d;
         ie_q            <= ie_d;
         ip_q            <= ip_d;
         exc_code_q      <= exc_code_d;
         timer_pending_q <= timer_pending_d;
      end
   end

   always_comb begin
      case (cp0_addr)
         ADDR_COUNT:   rdata = count_q;
         ADDR_COMPARE: rdata = compare_q;
         ADDR_STATUS:  rdata = {16'h0, im_q, 8'h0, exl_q, ie_q};
         ADDR_CAUSE:   rdata = {16'h0, ip_q, 3'b000, exc_code_q, 2'b00};
         ADDR_EPC:     rdata = epc_q;
         ADDR_PRID:    rdata = PRID_VALUE;
         default:      rdata = 32'h0;
      endcase
   end

   assign epc        = epc_q;
   assign exc_vector = EXC_VECTOR;

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: table of fault-priority vectors through a scoreboard queue,
// followed by hand-built sequences for ERET, MTC0, interrupts, timer and reset.
module tb_cp0_unit;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic        IsCOP0, IsEret, IsMtc0;
   logic [4:0]  cp0_addr;
   logic [31:0] wdata;
   logic        syscall, ri, ov;
   logic [5:0]  ext_int;
   logic        HasExp;
   logic [31:0] epc, exc_vector, rdata;
   logic        eret_taken;

   cp0_unit dut (
      .clk        (clk),
      .rst        (rst),
      .pc         (pc),
      .IsCOP0     (IsCOP0),
      .IsEret     (IsEret),
      .IsMtc0     (IsMtc0),
      .cp0_addr   (cp0_addr),
      .wdata      (wdata),
      .syscall    (syscall),
      .ri         (ri),
      .ov         (ov),
      .ext_int    (ext_int),
      .HasExp     (HasExp),
      .epc        (epc),
      .exc_vector (exc_vector),
      .rdata      (rdata),
      .eret_taken (eret_taken)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        sys;
      logic        ri;
      logic        ov;
      logic        exp_has;
      logic [4:0]  exp_code;
      logic [31:0] exp_epc;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] val;
   } sb_t;

   vec_t vecs [8];
   sb_t  sbq [$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic sb_push(input string name, input logic [31:0] val);
      sb_t e;
      e.name = name;
      e.val  = val;
      sbq.push_back(e);
   endtask

   task automatic sb_check(input logic [31:0] act);
      sb_t e;
      if (sbq.size() == 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL scoreboard_empty: got %h expected <queued value>", act);
      end else begin
         e = sbq.pop_front();
         check(e.name, act, e.val);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      IsCOP0  = 1'b0;
      IsEret  = 1'b0;
      IsMtc0  = 1'b0;
      syscall = 1'b0;
      ri      = 1'b0;
      ov      = 1'b0;
      wdata   = 32'h0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      cp0_addr = a;
      #1;
      d = rdata;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      IsCOP0   = 1'b1;
      IsMtc0   = 1'b1;
      cp0_addr = a;
      wdata    = d;
      tick();
      idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] d;

      vecs[0] = '{32'h0000_0040, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8,  32'h0000_0040};
      vecs[1] = '{32'h0000_0044, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8,  32'h0000_0040};
      vecs[2] = '{32'h0000_0048, 1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 32'h0000_0048};
      vecs[3] = '{32'h0000_004C, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8,  32'h0000_004C};
      vecs[4] = '{32'h0000_0050, 1'b0, 1'b0, 1'b1, 1'b1, 5'd12, 32'h0000_0050};
      vecs[5] = '{32'h0000_0054, 1'b0, 1'b1, 1'b1, 1'b1, 5'd10, 32'h0000_0054};
      vecs[6] = '{32'h0000_0058, 1'b1, 1'b1, 1'b1, 1'b1, 5'd10, 32'h0000_0058};
      vecs[7] = '{32'h0000_005C, 1'b0, 1'b0, 1'b0, 1'b0, 5'd10, 32'h0000_0058};

      // Reset with faults asserted: no exception may be reported.
      rst = 1'b1;
      pc = 32'h0;
      cp0_addr = 5'd0;
      ext_int = 6'h0;
      idle();
      syscall = 1'b1;
      ov = 1'b1;
      #1;
      check("has_exp_in_reset", {31'h0, HasExp}, 32'h0);
      tick();
      tick();
      rst = 1'b0;
      idle();
      #1;
      check("has_exp_after_reset", {31'h0, HasExp}, 32'h0);
      rd(5'd12, d); check("reset_status", d, 32'h0);
      rd(5'd13, d); check("reset_cause", d, 32'h0);
      rd(5'd14, d); check("reset_epc", d, 32'h0);
      rd(5'd11, d); check("reset_compare", d, 32'hFFFF_FFFF);
      rd(5'd9,  d); check("reset_count", d, 32'h0);
      rd(5'd15, d); check("prid", d, 32'h0001_0001);
      rd(5'd0,  d); check("unimpl_addr0", d, 32'h0);
      check("exc_vector", exc_vector, 32'h0000_0800);

      // Fault priority table, EXL stays set and EPC is overwritten on nested faults.
      for (int i = 0; i < 8; i++) begin
         pc      = vecs[i].pc;
         syscall = vecs[i].sys;
         ri      = vecs[i].ri;
         ov      = vecs[i].ov;
         sb_push($sformatf("v%0d_has_exp", i), {31'h0, vecs[i].exp_has});
         sb_push($sformatf("v%0d_cause", i), {25'h0, vecs[i].exp_code, 2'b00});
         sb_push($sformatf("v%0d_epc", i), vecs[i].exp_epc);
         sb_push($sformatf("v%0d_status", i), 32'h0000_0002);
         #1;
         sb_check({31'h0, HasExp});
         tick();
         idle();
         rd(5'd13, d); sb_check(d);
         rd(5'd14, d); sb_check(d);
         rd(5'd12, d); sb_check(d);
      end

      // ERET returns: EPC preserved, EXL cleared.
      mtc0(5'd14, 32'h0000_0100);
      check("epc_after_mtc0", epc, 32'h0000_0100);
      IsCOP0 = 1'b1;
      IsEret = 1'b1;
      #1;
      check("eret_has_exp", {31'h0, HasExp}, 32'h0);
      check("eret_taken", {31'h0, eret_taken}, 32'h1);
      check("eret_epc", epc, 32'h0000_0100);
      tick();
      idle();
      rd(5'd12, d); check("eret_status", d, 32'h0);
      check("eret_epc_after", epc, 32'h0000_0100);

      // ERET together with overflow is an exception, not a return.
      mtc0(5'd12, 32'h0000_0002);
      rd(5'd12, d); check("status_exl_write", d, 32'h0000_0002);
      IsCOP0 = 1'b1;
      IsEret = 1'b1;
      ov = 1'b1;
      pc = 32'h0000_0200;
      #1;
      check("eret_ov_has_exp", {31'h0, HasExp}, 32'h1);
      check("eret_ov_taken", {31'h0, eret_taken}, 32'h0);
      tick();
      idle();
      rd(5'd13, d); check("eret_ov_cause", d, 32'h0000_0030);
      rd(5'd12, d); check("eret_ov_status", d, 32'h0000_0002);
      check("eret_ov_epc", epc, 32'h0000_0200);

      // MTC0 colliding with syscall is dropped; Cause and PRId are not writable.
      IsCOP0 = 1'b1;
      IsMtc0 = 1'b1;
      cp0_addr = 5'd14;
      wdata = 32'h0000_DEAD;
      syscall = 1'b1;
      pc = 32'h0000_0300;
      tick();
      idle();
      check("mtc0_drop_epc", epc, 32'h0000_0300);
      mtc0(5'd13, 32'hFFFF_FFFF);
      rd(5'd13, d); check("cause_readonly", d, 32'h0000_0020);
      mtc0(5'd15, 32'h0);
      rd(5'd15, d); check("prid_readonly", d, 32'h0001_0001);

      // Hardware interrupt on IP[10], then masked by EXL.
      mtc0(5'd12, 32'h0000_0401);
      rd(5'd12, d); check("status_ie_im", d, 32'h0000_0401);
      ext_int = 6'b000001;
      pc = 32'h0000_0400;
      #1;
      check("int_before_latch", {31'h0, HasExp}, 32'h0);
      tick();
      check("int_after_latch", {31'h0, HasExp}, 32'h1);
      rd(5'd13, d); check("int_cause_ip", d, 32'h0000_0420);
      tick();
      check("int_masked_exl", {31'h0, HasExp}, 32'h0);
      rd(5'd12, d); check("int_status", d, 32'h0000_0403);
      rd(5'd13, d); check("int_cause_code0", d, 32'h0000_0400);
      check("int_epc", epc, 32'h0000_0400);
      tick();
      check("int_still_masked", {31'h0, HasExp}, 32'h0);
      ext_int = 6'h0;
      mtc0(5'd12, 32'h0);

      // Timer: Compare=5, Count=0; IP[15] rises two edges after Count reaches 5.
      mtc0(5'd11, 32'd5);
      rd(5'd11, d); check("compare_write", d, 32'd5);
      mtc0(5'd9, 32'd0);
      rd(5'd9, d); check("count_write", d, 32'd0);
      for (int i = 1; i <= 8; i++) begin
         tick();
         rd(5'd9, d); check($sformatf("timer_count_%0d", i), d, i);
         rd(5'd13, d);
         check($sformatf("timer_ip15_%0d", i), {31'h0, d[15]}, (i >= 7) ? 32'h1 : 32'h0);
      end
      mtc0(5'd11, 32'hFFFF_0000);
      rd(5'd11, d); check("compare_rewrite", d, 32'hFFFF_0000);
      tick();
      rd(5'd13, d); check("timer_ip15_cleared", {31'h0, d[15]}, 32'h0);

      // Count wraps to zero.
      mtc0(5'd9, 32'hFFFF_FFFE);
      rd(5'd9, d); check("wrap_fffe", d, 32'hFFFF_FFFE);
      tick();
      rd(5'd9, d); check("wrap_ffff", d, 32'hFFFF_FFFF);
      tick();
      rd(5'd9, d); check("wrap_zero", d, 32'h0);

      // Reset in the middle of a handler overrides a simultaneous fault and MTC0.
      syscall = 1'b1;
      pc = 32'h0000_0500;
      tick();
      idle();
      rd(5'd12, d); check("handler_status", d, 32'h0000_0002);
      check("handler_epc", epc, 32'h0000_0500);
      rst = 1'b1;
      syscall = 1'b1;
      IsCOP0 = 1'b1;
      IsMtc0 = 1'b1;
      cp0_addr = 5'd14;
      wdata = 32'h0000_0777;
      #1;
      check("rst_has_exp", {31'h0, HasExp}, 32'h0);
      tick();
      rst = 1'b0;
      idle();
      #1;
      check("rst2_has_exp", {31'h0, HasExp}, 32'h0);
      check("rst2_epc_port", epc, 32'h0);
      rd(5'd12, d); check("rst2_status", d, 32'h0);
      rd(5'd13, d); check("rst2_cause", d, 32'h0);
      rd(5'd11, d); check("rst2_compare", d, 32'hFFFF_FFFF);
      rd(5'd9,  d); check("rst2_count", d, 32'h0);

      if (sbq.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", sbq.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
